// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for the 5-stage pipeline. It drives the
// load enables and flushes of the PC and of the IF/ID, ID/EX and EX/MEM
// registers, and the EX-stage ALU operand-forwarding selects. It freezes the
// pipeline on data-memory wait states and halts on memory timeout. It also
// keeps a saturating count of stalled cycles.
//
// Build option: define PIPE_HAZARD_FWD_EN to enable operand forwarding. With
// forwarding, only a load-use conflict stalls. Without it, fwd_a/fwd_b are
// tied to 00 and any RAW match against EX, MEM or WB stalls.
//
// Parameters:
//   OP_LOAD      opcode of the load instruction (load-use detection)
//   RA_W         register-address width
//   MEM_TIMEOUT  maximum consecutive MEM_WAIT cycles before halting (2..255)
//
// Ports:
//   clock, reset                   rising-edge clock, sync active-high reset
//   id_rs1, id_rs2                 sources of the instruction in ID
//   id_ex_rs1, id_ex_rs2           sources of the instruction in EX
//   id_ex_rd/we/opcode             destination, write flag, opcode in EX
//   ex_mem_rd/we, mem_wb_rd/we     destination and write flag in MEM / WB
//   ex_branch_taken                branch/jump resolved taken in EX
//   mem_req, mem_ready             data-memory access / completion
//   pc_en, if_id_en, id_ex_en,
//   ex_mem_en                      register load enables
//   if_id_flush, id_ex_flush       load a NOP instead of data
//   fwd_a, fwd_b                   00 regfile, 01 EX/MEM, 10 MEM/WB
//   halted                         controller is in HALT
//   stall_cycles                   saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter logic [3:0]  OP_LOAD     = 4'b0010,
  parameter int unsigned RA_W        = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_ex_rs1,
  input  logic [RA_W-1:0] id_ex_rs2,
  input  logic [RA_W-1:0] id_ex_rd,
  input  logic            id_ex_we,
  input  logic [3:0]      id_ex_opcode,
  input  logic [RA_W-1:0] ex_mem_rd,
  input  logic            ex_mem_we,
  input  logic [RA_W-1:0] mem_wb_rd,
  input  logic            mem_wb_we,
  input  logic            ex_branch_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            halted,
  output logic [15:0]     stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wcnt;
  logic [7:0]  wcnt_nxt;
  logic [15:0] stall_cnt;
  logic        hazard;

  // Register writer 'rd' (with write flag 'we') conflicts with either source.
  function automatic logic raw_match(input logic [RA_W-1:0] rd,
                                     input logic            we,
                                     input logic [RA_W-1:0] rs1,
                                     input logic [RA_W-1:0] rs2);
    return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Select for one ALU operand; EX/MEM is younger and therefore wins.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (ex_mem_we && (ex_mem_rd != '0) && (ex_mem_rd == rs))
      return 2'b01;
    else if (mem_wb_we && (mem_wb_rd != '0) && (mem_wb_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

`ifdef PIPE_HAZARD_FWD_EN
  always_comb begin
    fwd_a  = fwd_sel(id_ex_rs1);
    fwd_b  = fwd_sel(id_ex_rs2);
    hazard = (id_ex_opcode == OP_LOAD) &&
             raw_match(id_ex_rd, id_ex_we, id_rs1, id_rs2);
  end
`else
  // Without forwarding the consumer waits in ID until the producer retires
  // from WB, so every in-flight writer is a hazard source.
  always_comb begin
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    hazard = raw_match(id_ex_rd,  id_ex_we,  id_rs1, id_rs2) ||
             raw_match(ex_mem_rd, ex_mem_we, id_rs1, id_rs2) ||
             raw_match(mem_wb_rd, mem_wb_we, id_rs1, id_rs2);
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{id_ex_rs1, id_ex_rs2, id_ex_opcode, OP_LOAD};
`endif

  // Pipeline controls and next-state decode.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_nxt   = state;
    wcnt_nxt    = wcnt;

    if (reset) begin
      id_ex_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_nxt = MEM_WAIT;
            wcnt_nxt  = 8'd1;
          end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hazard) begin
            // Hold PC and IF/ID; push a bubble into EX.
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
          end
        end

        MEM_WAIT: begin
          if (mem_ready) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            state_nxt = RUN;
            wcnt_nxt  = '0;
          end else if (wcnt == TIMEOUT_CNT) begin
            state_nxt = HALT;
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end

        HALT: begin
          state_nxt = HALT;
        end

        default: begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (!pc_en && (state != HALT) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign halted       = (state == HALT);
  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Scoreboard bench: each stimulus cycle pushes its hand-computed expected
// outputs into a queue; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic        id_ex_we;
  logic [3:0]  id_ex_opcode;
  logic [3:0]  ex_mem_rd, mem_wb_rd;
  logic        ex_mem_we, mem_wb_we;
  logic        ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic        if_id_flush, id_ex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        halted;
  logic [15:0] stall_cycles;

  pipeline_hazard_ctrl dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_we(id_ex_we), .id_ex_opcode(id_ex_opcode),
    .ex_mem_rd(ex_mem_rd), .ex_mem_we(ex_mem_we),
    .mem_wb_rd(mem_wb_rd), .mem_wb_we(mem_wb_we),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

`ifdef PIPE_HAZARD_FWD_EN
  localparam logic [1:0] F01 = 2'b01;
  localparam logic [1:0] F10 = 2'b10;
  localparam logic [3:0] EN_RAW = 4'b1111;
  localparam logic [1:0] FL_RAW = 2'b00;
`else
  localparam logic [1:0] F01 = 2'b00;
  localparam logic [1:0] F10 = 2'b00;
  localparam logic [3:0] EN_RAW = 4'b0011;
  localparam logic [1:0] FL_RAW = 2'b01;
`endif
  localparam logic [3:0] ALL = 4'b1111;

  typedef struct {
    string       tag;
    logic [3:0]  en;   // {pc, if_id, id_ex, ex_mem}
    logic [1:0]  fl;   // {if_id, id_ex}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        h;
    logic [15:0] st;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_stall = '0;

  task automatic chk(input string tag, input string what,
                     input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h", tag, what, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, "enables", 16'({pc_en, if_id_en, id_ex_en, ex_mem_en}), 16'(e.en));
      chk(e.tag, "flushes", 16'({if_id_flush, id_ex_flush}), 16'(e.fl));
      chk(e.tag, "fwd_a", 16'(fwd_a), 16'(e.fa));
      chk(e.tag, "fwd_b", 16'(fwd_b), 16'(e.fb));
      chk(e.tag, "halted", 16'(halted), 16'(e.h));
      chk(e.tag, "stall_cycles", stall_cycles, e.st);
    end
  end

  task automatic clr();
    reset = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_ex_rs1 = '0; id_ex_rs2 = '0;
    id_ex_rd = '0; id_ex_we = 1'b0; id_ex_opcode = '0;
    ex_mem_rd = '0; ex_mem_we = 1'b0; mem_wb_rd = '0; mem_wb_we = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    clr();
  endtask

  // Push the expectation for the current cycle; the stall count seen this
  // cycle is the one accumulated by earlier cycles.
  task automatic step(input string tag, input logic [3:0] en, input logic [1:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic h);
    exp_t e;
    e.tag = tag; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.h = h;
    e.st = exp_stall;
    q.push_back(e);
    if (reset) exp_stall = '0;
    else if (!en[3] && !h && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  task automatic load_use_r3();
    id_ex_opcode = 4'b0010; id_ex_we = 1'b1; id_ex_rd = 4'd3;
    id_rs1 = 4'd1; id_rs2 = 4'd3;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    step("reset", 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0);
    cyc(); step("idle", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Load-use: exactly one bubble.
    cyc(); load_use_r3(); step("ldu", 4'b0011, 2'b01, 2'b00, 2'b00, 1'b0);
    cyc(); step("ldu_after", ALL, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); id_ex_opcode = 4'b0010; id_ex_we = 1'b1; id_ex_rd = 4'd0;
    step("ld_rd0", ALL, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); id_ex_opcode = 4'b0010; id_ex_we = 1'b0; id_ex_rd = 4'd3; id_rs1 = 4'd3;
    step("ld_nowe", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Branch beats load-use.
    cyc(); load_use_r3(); ex_branch_taken = 1'b1;
    step("br_ldu", ALL, 2'b11, 2'b00, 2'b00, 1'b0);
    cyc(); step("br_after", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Forwarding selects.
    cyc(); ex_mem_rd = 4'd5; ex_mem_we = 1'b1; mem_wb_rd = 4'd5; mem_wb_we = 1'b1; id_ex_rs1 = 4'd5;
    step("fwd_exmem", ALL, 2'b00, F01, 2'b00, 1'b0);
    cyc(); ex_mem_rd = 4'd5; mem_wb_rd = 4'd5; mem_wb_we = 1'b1; id_ex_rs1 = 4'd5;
    step("fwd_memwb", ALL, 2'b00, F10, 2'b00, 1'b0);
    cyc(); ex_mem_we = 1'b1; mem_wb_we = 1'b1;
    step("fwd_rd0", ALL, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); ex_mem_rd = 4'd6; ex_mem_we = 1'b1; mem_wb_rd = 4'd7; mem_wb_we = 1'b1;
    id_ex_rs1 = 4'd7; id_ex_rs2 = 4'd6;
    step("fwd_both", ALL, 2'b00, F10, F01, 1'b0);

    // ALU writer of r2 followed by a reader of r2.
    cyc(); id_rs1 = 4'd2; id_ex_rd = 4'd2; id_ex_we = 1'b1; id_ex_opcode = 4'b0001;
    step("raw_ex", EN_RAW, FL_RAW, 2'b00, 2'b00, 1'b0);
    cyc(); id_rs1 = 4'd2; ex_mem_rd = 4'd2; ex_mem_we = 1'b1;
    step("raw_mem", EN_RAW, FL_RAW, 2'b00, 2'b00, 1'b0);
    cyc(); id_rs1 = 4'd2; mem_wb_rd = 4'd2; mem_wb_we = 1'b1;
    step("raw_wb", EN_RAW, FL_RAW, 2'b00, 2'b00, 1'b0);
    cyc(); id_rs1 = 4'd2;
    step("raw_done", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Memory wait, ready after 4 cycles; branch and hazard ignored while frozen.
    cyc(); mem_req = 1'b1; step("mw_req", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(); mem_req = 1'b1;
      if (i == 1) begin ex_mem_rd = 4'd5; ex_mem_we = 1'b1; id_ex_rs1 = 4'd5; end
      if (i == 2) ex_branch_taken = 1'b1;
      if (i == 3) load_use_r3();
      step("mw_wait", 4'b0000, 2'b00, (i == 1) ? F01 : 2'b00, 2'b00, 1'b0);
    end
    cyc(); mem_req = 1'b1; mem_ready = 1'b1;
    step("mw_ready", ALL, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); step("mw_after", ALL, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); mem_req = 1'b1; mem_ready = 1'b1;
    step("mw_hit", ALL, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); step("mw_hit_after", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Ready on the last legal wait cycle (N = MEM_TIMEOUT).
    cyc(); mem_req = 1'b1; step("edge_req", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc(); mem_req = 1'b1; step("edge_wait", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    cyc(); mem_req = 1'b1; mem_ready = 1'b1;
    step("edge_ready", ALL, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); step("edge_after", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Timeout: 16 wait cycles then HALT, which ignores ready and branch.
    cyc(); mem_req = 1'b1; step("to_req", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(); mem_req = 1'b1; step("to_wait", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_ready = 1'b1; ex_branch_taken = 1'b1;
      step("halt", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1);
    end
    cyc(); reset = 1'b1; step("rst_halt", 4'b0000, 2'b01, 2'b00, 2'b00, 1'b1);
    cyc(); step("post_rst", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Reset in the middle of a memory wait.
    cyc(); mem_req = 1'b1; step("rw_req", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); mem_req = 1'b1; step("rw_wait", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc(); mem_req = 1'b1; reset = 1'b1;
    step("rw_rst", 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0);
    cyc(); step("rw_run", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Saturation of the stall counter.
    for (int i = 0; i < 65540; i++) begin
      cyc(); load_use_r3(); step("sat", 4'b0011, 2'b01, 2'b00, 2'b00, 1'b0);
    end
    cyc(); step("sat_end", ALL, 2'b00, 2'b00, 2'b00, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
